// File: rtl/alu_exec_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_pipe
// Description : EX-stage ALU of the pipelined MIPS core. Decodes the 3-bit
//               ALUControl code (AND/OR/ADD/SUB/SLT) in a two-stage
//               valid/ready pipeline. S1 latches operands and control. S2
//               computes and registers the result plus its flags. The pipe
//               sustains one op per cycle and supports full backpressure.
// Ports       : clk, reset_n (sync, active-low)
//               in_valid/in_ready, alu_control[2:0], src_a/src_b[WIDTH]
//               out_valid/out_ready, alu_result[WIDTH], zero, illegal_op,
//               overflow, trap (only with ALU_OVF_TRAP_EN)
// Config      : `define ALU_OVF_TRAP_EN to add the sticky trap output. A
//               trap is raised by an overflowing or illegal op, and it
//               stops new ops from being accepted until reset.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_pipe #(
  parameter int WIDTH    = 32,
  parameter int SHAMT_EN = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             illegal_op,
  output logic             overflow
`ifdef ALU_OVF_TRAP_EN
  ,
  output logic             trap
`endif
);

  localparam logic [2:0] c_ctl_and = 3'b000;
  localparam logic [2:0] c_ctl_or  = 3'b001;
  localparam logic [2:0] c_ctl_add = 3'b010;
  localparam logic [2:0] c_ctl_sub = 3'b110;
  localparam logic [2:0] c_ctl_slt = 3'b111;

  // SHAMT_EN is reserved and must be 0. A non-zero value flags every op
  // as illegal, so the misconfiguration is visible on illegal_op.
  localparam logic c_cfg_ok = (SHAMT_EN == 0);

  // Stage 1: operand/control holding register
  logic             r_s1_valid;
  logic [2:0]       r_s1_ctl;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;

  // Stage 2: registered result and flags
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_illegal;
  logic             r_ovf;

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_hold;

  logic             w_sub;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH-1:0] w_sum;
  logic             w_add_ovf;
  logic [WIDTH-1:0] w_result;
  logic             w_illegal;
  logic             w_ovf;

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  assign w_s2_adv   = ~r_s2_valid | out_ready;
  assign w_s1_adv   = r_s1_valid & w_s2_adv;
  assign w_in_ready = (~r_s1_valid | w_s2_adv) & ~w_hold;
  assign w_accept   = in_valid & w_in_ready;

  // --------------------------------------------------------------------------
  // ALU datapath
  // --------------------------------------------------------------------------
  // ADD, SUB and SLT share a single adder. SUB and SLT use a + ~b + 1.
  assign w_sub     = (r_s1_ctl == c_ctl_sub) | (r_s1_ctl == c_ctl_slt);
  assign w_b_eff   = w_sub ? ~r_s1_b : r_s1_b;
  assign w_sum     = r_s1_a + w_b_eff + {{(WIDTH-1){1'b0}}, w_sub};
  assign w_add_ovf = (r_s1_a[WIDTH-1] == w_b_eff[WIDTH-1]) &
                     (w_sum[WIDTH-1] != r_s1_a[WIDTH-1]);

  always_comb begin
    w_result  = '0;
    w_illegal = 1'b0;
    w_ovf     = 1'b0;
    case (r_s1_ctl)
      c_ctl_and: w_result = r_s1_a & r_s1_b;
      c_ctl_or:  w_result = r_s1_a | r_s1_b;
      c_ctl_add: begin
        w_result = w_sum;
        w_ovf    = w_add_ovf;
      end
      c_ctl_sub: begin
        w_result = w_sum;
        w_ovf    = w_add_ovf;
      end
      // The sign of the difference is wrong exactly when the subtraction
      // overflowed. XOR-ing the two gives the true signed a<b.
      c_ctl_slt: w_result = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_add_ovf};
      default:   w_illegal = 1'b1;
    endcase
    if (!c_cfg_ok) begin
      w_result  = '0;
      w_illegal = 1'b1;
      w_ovf     = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Pipeline registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_ctl   <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s2_valid <= 1'b0;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_illegal  <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      // S1 refills in the same edge that it hands its op to S2.
      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_s1_ctl   <= alu_control;
        r_s1_a     <= src_a;
        r_s1_b     <= src_b;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end

      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        // The payload is loaded only with a real op. After the stage drains,
        // the last result stays on the bus.
        if (r_s1_valid) begin
          r_result  <= w_result;
          // This is the zero test of the value being registered, so it
          // always matches alu_result.
          r_zero    <= (w_result == '0);
          r_illegal <= w_illegal;
          r_ovf     <= w_ovf;
        end
      end
    end
  end

`ifdef ALU_OVF_TRAP_EN
  logic r_trap;

  // The trap is set in the same edge that registers the offending result.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_trap <= 1'b0;
    end else if (w_s1_adv & (w_ovf | w_illegal)) begin
      r_trap <= 1'b1;
    end
  end

  assign w_hold = r_trap;
  assign trap   = r_trap;
`else
  assign w_hold = 1'b0;
`endif

  assign in_ready   = w_in_ready;
  assign out_valid  = r_s2_valid;
  assign alu_result = r_result;
  assign zero       = r_zero;
  assign illegal_op = r_illegal;
  assign overflow   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_pipe
// Description : Directed self-checking bench for alu_exec_pipe. It covers
//               reset, latency, arithmetic corner cases, back-to-back
//               throughput, a backpressure stream and illegal codes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_pipe;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_control;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_result;
  logic             zero;
  logic             illegal_op;
  logic             overflow;
`ifdef ALU_OVF_TRAP_EN
  logic             trap;
`endif

  int n_checks = 0;
  int n_errors = 0;

  alu_exec_pipe #(.WIDTH(WIDTH), .SHAMT_EN(0)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_result  (alu_result),
    .zero        (zero),
    .illegal_op  (illegal_op),
    .overflow    (overflow)
`ifdef ALU_OVF_TRAP_EN
    ,
    .trap        (trap)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock edge. Outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    step();
    reset_n  = 1'b1;
  endtask

  // Issue one op and wait two edges. At return the result should be valid.
  task automatic issue(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b);
    in_valid    = 1'b1;
    alu_control = ctl;
    src_a       = a;
    src_b       = b;
    step();
    in_valid = 1'b0;
    check_eq("lat_not_yet", {31'd0, out_valid}, 32'd0);
    step();
    check_eq("lat_valid", {31'd0, out_valid}, 32'd1);
  endtask

  // Stimulus and hand-computed results for the backpressure stream.
  logic [2:0]  s_ctl [4] = '{3'b010, 3'b010, 3'b110, 3'b001};
  logic [31:0] s_a   [4] = '{32'd1, 32'd2, 32'd10, 32'h100};
  logic [31:0] s_b   [4] = '{32'd1, 32'd2, 32'd3,  32'h001};
  logic [31:0] s_exp [4] = '{32'd2, 32'd4, 32'd7,  32'h101};

  initial begin
    int idx_in;
    int idx_out;
    logic fire_in;
    logic fire_out;

    reset_n     = 1'b0;
    in_valid    = 1'b1;
    out_ready   = 1'b1;
    alu_control = 3'b010;
    src_a       = 32'h1234;
    src_b       = 32'h1;

    // 1: reset held for 3 cycles with in_valid high
    repeat (3) step();
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_result", alu_result, 32'd0);
    check_eq("rst_zero", {31'd0, zero}, 32'd0);
    check_eq("rst_illegal", {31'd0, illegal_op}, 32'd0);
    check_eq("rst_overflow", {31'd0, overflow}, 32'd0);
    reset_n  = 1'b1;
    in_valid = 1'b0;
    #1;
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    check_eq("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

    // 2: ADD with signed overflow
    issue(3'b010, 32'h7FFF_FFFF, 32'h1);
    check_eq("add_ovf_result", alu_result, 32'h8000_0000);
    check_eq("add_ovf_flag", {31'd0, overflow}, 32'd1);
    check_eq("add_ovf_zero", {31'd0, zero}, 32'd0);
    check_eq("add_ovf_illegal", {31'd0, illegal_op}, 32'd0);
    step();
    check_eq("add_drained", {31'd0, out_valid}, 32'd0);
    do_reset();

    // 3: SUB to zero, SUB with overflow, SLT across the sign boundary
    issue(3'b110, 32'd5, 32'd5);
    check_eq("sub_eq_result", alu_result, 32'd0);
    check_eq("sub_eq_zero", {31'd0, zero}, 32'd1);
    check_eq("sub_eq_ovf", {31'd0, overflow}, 32'd0);
    issue(3'b110, 32'h8000_0000, 32'h1);
    check_eq("sub_ovf_result", alu_result, 32'h7FFF_FFFF);
    check_eq("sub_ovf_flag", {31'd0, overflow}, 32'd1);
    do_reset();
    issue(3'b111, 32'h8000_0000, 32'h1);
    check_eq("slt_neg_lt", alu_result, 32'd1);
    check_eq("slt_ovf_flag", {31'd0, overflow}, 32'd0);
    check_eq("slt_zero", {31'd0, zero}, 32'd0);
    issue(3'b111, 32'h1, 32'h8000_0000);
    check_eq("slt_pos_ge", alu_result, 32'd0);
    check_eq("slt_ge_zero", {31'd0, zero}, 32'd1);
    issue(3'b111, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
    check_eq("slt_neg_neg", alu_result, 32'd1);
    step();

    // 4: back-to-back AND, OR, ADD without bubbles
    in_valid    = 1'b1;
    alu_control = 3'b000; src_a = 32'hF0F0; src_b = 32'h0FF0;
    step();
    check_eq("b2b_lat", {31'd0, out_valid}, 32'd0);
    alu_control = 3'b001;
    #1;
    check_eq("b2b_ready1", {31'd0, in_ready}, 32'd1);
    step();
    check_eq("b2b_and_valid", {31'd0, out_valid}, 32'd1);
    check_eq("b2b_and", alu_result, 32'h0000_00F0);
    alu_control = 3'b010; src_a = 32'd3; src_b = 32'd4;
    #1;
    check_eq("b2b_ready2", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check_eq("b2b_or_valid", {31'd0, out_valid}, 32'd1);
    check_eq("b2b_or", alu_result, 32'h0000_FFF0);
    step();
    check_eq("b2b_add_valid", {31'd0, out_valid}, 32'd1);
    check_eq("b2b_add", alu_result, 32'd7);
    step();
    check_eq("b2b_drained", {31'd0, out_valid}, 32'd0);

    // 5: 4-op stream with out_ready low for the first 4 cycles
    idx_in  = 0;
    idx_out = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      out_ready = (cyc >= 4);
      in_valid  = (idx_in < 4);
      if (idx_in < 4) begin
        alu_control = s_ctl[idx_in];
        src_a       = s_a[idx_in];
        src_b       = s_b[idx_in];
      end
      #1;
      if (cyc == 2) begin
        check_eq("bp_accepts", idx_in, 32'd2);
        check_eq("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      end
      fire_in  = in_valid & in_ready;
      fire_out = out_valid & out_ready;
      if (out_valid) begin
        if (idx_out < 4) check_eq("bp_result", alu_result, s_exp[idx_out]);
        else             check_eq("bp_extra_out", {31'd0, out_valid}, 32'd0);
      end
      step();
      if (fire_in)  idx_in++;
      if (fire_out) idx_out++;
    end
    in_valid = 1'b0;
    check_eq("bp_all_in", idx_in, 32'd4);
    check_eq("bp_all_out", idx_out, 32'd4);
    check_eq("bp_drained", {31'd0, out_valid}, 32'd0);

    // 6: illegal control code
    out_ready = 1'b1;
    issue(3'b101, 32'd1, 32'd1);
    check_eq("ill_result", alu_result, 32'd0);
    check_eq("ill_zero", {31'd0, zero}, 32'd1);
    check_eq("ill_flag", {31'd0, illegal_op}, 32'd1);
    check_eq("ill_ovf", {31'd0, overflow}, 32'd0);
`ifdef ALU_OVF_TRAP_EN
    check_eq("trap_set", {31'd0, trap}, 32'd1);
    repeat (3) step();
    check_eq("trap_hold_ready", {31'd0, in_ready}, 32'd0);
    check_eq("trap_sticky", {31'd0, trap}, 32'd1);
    do_reset();
    #1;
    check_eq("trap_cleared", {31'd0, trap}, 32'd0);
    check_eq("trap_ready_back", {31'd0, in_ready}, 32'd1);
`else
    step();
    check_eq("ill_ready", {31'd0, in_ready}, 32'd1);
`endif
    issue(3'b011, 32'hFFFF_FFFF, 32'h1);
    check_eq("ill011_result", alu_result, 32'd0);
    check_eq("ill011_flag", {31'd0, illegal_op}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
